// File: rtl/mcu_mailbox_endpoint.sv
// rtl/mcu_mailbox_endpoint.sv - LSU-side mailbox endpoint with TX/RX flit FIFOs
module mcu_mailbox_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ready and valid come only from the registered count, so there is no valid->ready path
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers wrap naturally since DEPTH is a power of two; count is one bit wider than pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: nothing is visible until count says so
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

module mcu_mailbox_endpoint #(
  parameter logic [15:0] SRC_ID   = 16'h0000,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mailbox_tx_valid,
  output logic                        mailbox_tx_ready,
  input  logic [15:0]                 mailbox_tx_dest,
  input  logic [31:0]                 mailbox_tx_data,
  input  logic                        mailbox_tx_prio,
  input  logic                        mailbox_tx_eop,
  input  logic [3:0]                  mailbox_tx_opcode,
  output logic                        mailbox_rx_valid,
  output logic [31:0]                 mailbox_rx_data,
  input  logic                        mailbox_rx_ready,
  output logic [15:0]                 mailbox_rx_src,
  output logic                        net_tx_valid,
  input  logic                        net_tx_ready,
  output logic [69:0]                 net_tx_flit,
  input  logic                        net_rx_valid,
  output logic                        net_rx_ready,
  input  logic [69:0]                 net_rx_flit,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        rx_irq
);
  logic [69:0] tx_flit_in;
  logic [47:0] rx_entry_in;
  logic [47:0] rx_entry_out;
  logic        unused_rx_fields;

  // Outgoing flit is fully formed at push time, stamped with this node's id
  assign tx_flit_in = {mailbox_tx_dest, SRC_ID, mailbox_tx_prio, mailbox_tx_eop,
                       mailbox_tx_opcode, mailbox_tx_data};

  // Inbound flits keep only source id and payload; dest/prio/eop/opcode are dropped
  assign rx_entry_in      = {net_rx_flit[53:38], net_rx_flit[31:0]};
  assign unused_rx_fields = ^{net_rx_flit[69:54], net_rx_flit[37:32]};

  mcu_mailbox_fifo #(.W(70), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mailbox_tx_valid),
    .in_ready  (mailbox_tx_ready),
    .in_data   (tx_flit_in),
    .out_valid (net_tx_valid),
    .out_ready (net_tx_ready),
    .out_data  (net_tx_flit),
    .count     (tx_count)
  );

  mcu_mailbox_fifo #(.W(48), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (net_rx_valid),
    .in_ready  (net_rx_ready),
    .in_data   (rx_entry_in),
    .out_valid (mailbox_rx_valid),
    .out_ready (mailbox_rx_ready),
    .out_data  (rx_entry_out),
    .count     (rx_count)
  );

  assign mailbox_rx_src  = rx_entry_out[47:32];
  assign mailbox_rx_data = rx_entry_out[31:0];
  assign rx_irq          = mailbox_rx_valid;
endmodule

// File: tb/tb_mcu_mailbox_endpoint.sv
// tb/tb_mcu_mailbox_endpoint.sv - self-checking bench for mcu_mailbox_endpoint
module tb_mcu_mailbox_endpoint;
  localparam logic [15:0] SRC = 16'h0003;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mailbox_tx_valid, mailbox_tx_ready;
  logic [15:0] mailbox_tx_dest;
  logic [31:0] mailbox_tx_data;
  logic        mailbox_tx_prio, mailbox_tx_eop;
  logic [3:0]  mailbox_tx_opcode;
  logic        mailbox_rx_valid, mailbox_rx_ready;
  logic [31:0] mailbox_rx_data;
  logic [15:0] mailbox_rx_src;
  logic        net_tx_valid, net_tx_ready;
  logic [69:0] net_tx_flit;
  logic        net_rx_valid, net_rx_ready;
  logic [69:0] net_rx_flit;
  logic [2:0]  tx_count, rx_count;
  logic        rx_irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mcu_mailbox_endpoint #(.SRC_ID(SRC), .TX_DEPTH(D), .RX_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .mailbox_tx_valid(mailbox_tx_valid), .mailbox_tx_ready(mailbox_tx_ready),
    .mailbox_tx_dest(mailbox_tx_dest), .mailbox_tx_data(mailbox_tx_data),
    .mailbox_tx_prio(mailbox_tx_prio), .mailbox_tx_eop(mailbox_tx_eop),
    .mailbox_tx_opcode(mailbox_tx_opcode),
    .mailbox_rx_valid(mailbox_rx_valid), .mailbox_rx_data(mailbox_rx_data),
    .mailbox_rx_ready(mailbox_rx_ready), .mailbox_rx_src(mailbox_rx_src),
    .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready), .net_tx_flit(net_tx_flit),
    .net_rx_valid(net_rx_valid), .net_rx_ready(net_rx_ready), .net_rx_flit(net_rx_flit),
    .tx_count(tx_count), .rx_count(rx_count), .rx_irq(rx_irq)
  );

  typedef struct {
    logic tv;
    logic ntr;
    logic nrv;
    logic rr;
    int   txc;
    int   rxc;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [69:0] mk_flit(input logic [15:0] dst, input logic [15:0] src,
                                          input logic pr, input logic ep,
                                          input logic [3:0] op, input logic [31:0] dat);
    return {dst, src, pr, ep, op, dat};
  endfunction

  task automatic check_empty_state(input string tag);
    check({tag, "_net_tx_valid"}, 70'(net_tx_valid), 70'(0));
    check({tag, "_rx_valid"}, 70'(mailbox_rx_valid), 70'(0));
    check({tag, "_rx_irq"}, 70'(rx_irq), 70'(0));
    check({tag, "_tx_count"}, 70'(tx_count), 70'(0));
    check({tag, "_rx_count"}, 70'(rx_count), 70'(0));
    check({tag, "_tx_ready"}, 70'(mailbox_tx_ready), 70'(1));
    check({tag, "_net_rx_ready"}, 70'(net_rx_ready), 70'(1));
  endtask

  logic [69:0] txq[$];
  logic [47:0] rxq[$];
  logic        tx_hold, rx_hold;
  logic        tx_push, tx_pop, rx_push, rx_pop;

  initial begin
    // tv ntr nrv rr -> tx_count rx_count after the edge
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 2};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3, 3};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 4};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 3};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 3};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 2};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0};

    rst_n = 1'b0;
    mailbox_tx_valid = 0; mailbox_tx_dest = 0; mailbox_tx_data = 0;
    mailbox_tx_prio = 0; mailbox_tx_eop = 0; mailbox_tx_opcode = 0;
    mailbox_rx_ready = 0; net_tx_ready = 0; net_rx_valid = 0; net_rx_flit = '0;
    step();
    check_empty_state("in_reset");
    step();
    rst_n = 1'b1;
    step();
    check_empty_state("idle");

    // Single TX
    net_tx_ready = 1;
    mailbox_tx_valid = 1; mailbox_tx_dest = 16'h0005; mailbox_tx_data = 32'hDEADBEEF;
    mailbox_tx_prio = 0; mailbox_tx_eop = 1; mailbox_tx_opcode = 4'h0;
    step();
    mailbox_tx_valid = 0;
    check("single_net_tx_valid", 70'(net_tx_valid), 70'(1));
    check("single_flit", net_tx_flit, mk_flit(16'h0005, 16'h0003, 1'b0, 1'b1, 4'h0, 32'hDEADBEEF));
    check("single_tx_count1", 70'(tx_count), 70'(1));
    step();
    check("single_tx_count0", 70'(tx_count), 70'(0));
    check("single_net_tx_valid0", 70'(net_tx_valid), 70'(0));

    // Table-driven occupancy/ready vectors
    for (int i = 0; i < 12; i++) begin
      mailbox_tx_valid = tbl[i].tv; mailbox_tx_data = 32'(i);
      net_tx_ready = tbl[i].ntr; net_rx_valid = tbl[i].nrv; mailbox_rx_ready = tbl[i].rr;
      net_rx_flit = mk_flit(16'h1111, 16'h0040, 1'b0, 1'b0, 4'h0, 32'(i));
      step();
      check($sformatf("tbl%0d_tx_count", i), 70'(tx_count), 70'(tbl[i].txc));
      check($sformatf("tbl%0d_rx_count", i), 70'(rx_count), 70'(tbl[i].rxc));
      check($sformatf("tbl%0d_tx_ready", i), 70'(mailbox_tx_ready), 70'(tbl[i].txc != D));
      check($sformatf("tbl%0d_net_rx_ready", i), 70'(net_rx_ready), 70'(tbl[i].rxc != D));
      check($sformatf("tbl%0d_net_tx_valid", i), 70'(net_tx_valid), 70'(tbl[i].txc != 0));
      check($sformatf("tbl%0d_rx_irq", i), 70'(rx_irq), 70'(tbl[i].rxc != 0));
    end
    mailbox_tx_valid = 0; net_rx_valid = 0; mailbox_rx_ready = 0;

    // TX fill, held 5th word, drain in order
    net_tx_ready = 0; mailbox_tx_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      mailbox_tx_data = 32'(i);
      step();
    end
    check("fill_tx_count4", 70'(tx_count), 70'(4));
    check("fill_tx_ready0", 70'(mailbox_tx_ready), 70'(0));
    mailbox_tx_data = 32'd5;
    step();
    check("fill_5th_held", 70'(tx_count), 70'(4));
    net_tx_ready = 1;
    #1;
    check("fill_head1", 70'(net_tx_flit[31:0]), 70'(1));
    step();
    check("fill_after_pop_count", 70'(tx_count), 70'(3));
    check("fill_ready_back", 70'(mailbox_tx_ready), 70'(1));
    check("fill_head2", 70'(net_tx_flit[31:0]), 70'(2));
    step();
    mailbox_tx_valid = 0;
    check("fill_push5_count", 70'(tx_count), 70'(3));
    for (int i = 3; i <= 5; i++) begin
      check($sformatf("fill_head%0d", i), 70'(net_tx_flit[31:0]), 70'(i));
      step();
    end
    check("fill_drained", 70'(tx_count), 70'(0));
    net_tx_ready = 0;

    // RX path
    net_rx_valid = 1;
    net_rx_flit = mk_flit(16'hABCD, 16'h0009, 1'b1, 1'b1, 4'hF, 32'h12345678);
    step();
    net_rx_valid = 0;
    check("rx_valid", 70'(mailbox_rx_valid), 70'(1));
    check("rx_irq", 70'(rx_irq), 70'(1));
    check("rx_data", 70'(mailbox_rx_data), 70'(32'h12345678));
    check("rx_src", 70'(mailbox_rx_src), 70'(16'h0009));
    mailbox_rx_ready = 1;
    step();
    mailbox_rx_ready = 0;
    check("rx_popped", 70'(mailbox_rx_valid), 70'(0));

    // RX full with simultaneous pop and refused push
    net_rx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      net_rx_flit = mk_flit(16'h0, 16'h0020, 1'b0, 1'b0, 4'h0, 32'(100 + i));
      step();
    end
    check("rxfull_count4", 70'(rx_count), 70'(4));
    check("rxfull_net_rx_ready0", 70'(net_rx_ready), 70'(0));
    net_rx_flit = mk_flit(16'h0, 16'h0021, 1'b0, 1'b0, 4'h0, 32'd200);
    mailbox_rx_ready = 1;
    step();
    check("rxfull_pop_no_push", 70'(rx_count), 70'(3));
    mailbox_rx_ready = 0;
    step();
    net_rx_valid = 0;
    check("rxfull_late_push", 70'(rx_count), 70'(4));
    mailbox_rx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rxfull_drain%0d", i), 70'(mailbox_rx_data), 70'((i < 3) ? 101 + i : 200));
      step();
    end
    mailbox_rx_ready = 0;
    check("rxfull_drained", 70'(rx_count), 70'(0));

    // Reset mid-operation
    net_tx_ready = 0; mailbox_tx_valid = 1; net_rx_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mailbox_tx_data = 32'(300 + i);
      if (i == 2) net_rx_valid = 0;
      step();
    end
    mailbox_tx_valid = 0;
    check("mid_tx_count3", 70'(tx_count), 70'(3));
    check("mid_rx_count2", 70'(rx_count), 70'(2));
    rst_n = 0;
    #1;
    check_empty_state("mid_reset");
    step();
    rst_n = 1;
    net_tx_ready = 1;
    step();
    step();
    check_empty_state("post_reset");

    // Randomised traffic against a queue model
    tx_hold = 0; rx_hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (!tx_hold) begin
        mailbox_tx_valid = 1'($urandom_range(0, 1));
        mailbox_tx_dest = 16'($urandom); mailbox_tx_data = $urandom;
        mailbox_tx_prio = 1'($urandom); mailbox_tx_eop = 1'($urandom);
        mailbox_tx_opcode = 4'($urandom);
      end
      if (!rx_hold) begin
        net_rx_valid = 1'($urandom_range(0, 1));
        net_rx_flit = {6'($urandom), $urandom, $urandom};
      end
      net_tx_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mailbox_rx_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_tx_count", 70'(tx_count), 70'(txq.size()));
      check("rnd_rx_count", 70'(rx_count), 70'(rxq.size()));
      check("rnd_tx_ready", 70'(mailbox_tx_ready), 70'(txq.size() < D));
      check("rnd_net_rx_ready", 70'(net_rx_ready), 70'(rxq.size() < D));
      check("rnd_net_tx_valid", 70'(net_tx_valid), 70'(txq.size() > 0));
      check("rnd_rx_valid", 70'(mailbox_rx_valid), 70'(rxq.size() > 0));
      if (txq.size() > 0) check("rnd_tx_flit", net_tx_flit, txq[0]);
      if (rxq.size() > 0) check("rnd_rx_word", 70'({mailbox_rx_src, mailbox_rx_data}), 70'(rxq[0]));
      tx_push = mailbox_tx_valid && (txq.size() < D);
      tx_pop  = net_tx_ready && (txq.size() > 0);
      rx_push = net_rx_valid && (rxq.size() < D);
      rx_pop  = mailbox_rx_ready && (rxq.size() > 0);
      @(posedge clk);
      if (tx_pop) void'(txq.pop_front());
      if (tx_push) txq.push_back(mk_flit(mailbox_tx_dest, SRC, mailbox_tx_prio, mailbox_tx_eop,
                                         mailbox_tx_opcode, mailbox_tx_data));
      if (rx_pop) void'(rxq.pop_front());
      if (rx_push) rxq.push_back({net_rx_flit[53:38], net_rx_flit[31:0]});
      tx_hold = mailbox_tx_valid && !tx_push;
      rx_hold = net_rx_valid && !rx_push;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
